pipe_hazard_ctrl: RTL
=====================

# pipe_hazard_ctrl

Parametrised interlock, forwarding and flush controller for the pipelined CPU core. It tracks every in-flight register write from EX through WB in a shift-register scoreboard. It stalls the fetch/decode stages on unresolved data hazards, produces registered forwarding selects for the EX-stage operand muxes, and flushes wrong-path instructions on a taken branch. It replaces the core's hard-wired "no hazard" behaviour and generalises it to any pipeline depth, load latency and branch-resolve stage.

## Interface
- DEPTH, 3: number of post-decode slots (slot 0 = EX, slot DEPTH-1 = WB); legal range ≥ 2
- REG_NUM_WIDTH, 5: register number width
- LOAD_SLOT, 2: first slot index at which load data can be forwarded; range 1..DEPTH-1
- BR_SLOT, 1: slot index whose branch outcome drives `brTaken`; range 1..DEPTH-1
- CNT_WIDTH, 32: width of the performance counters
- clk  in  1  clock; the block has one clock
- rst  in  1  reset; synchronous and active-high
- idValid  in  1  ID stage holds a real instruction
- idRs, idRt  in  REG_NUM_WIDTH  source register numbers
- idUseA, idUseB  in  1  instruction reads idRs / idRt
- idWrEnable  in  1  instruction writes a register
- idWrNum  in  REG_NUM_WIDTH  destination register
- idIsLoad  in  1  instruction is a load
- brTaken  in  1  branch in slot BR_SLOT resolves taken this cycle
- stall  out  1  hold PC and IF/ID; insert a bubble into ID/EX (combinational)
- flush  out  1  clear IF/ID and ID/EX contents (combinational)
- fwdSelA, fwdSelB  out  $clog2(DEPTH)  operand source for the instruction now in EX: 0 = value read in ID, k = result held in slot k (registered)
- stallCount, flushCount  out  CNT_WIDTH  saturating event counters (registered)

## Operation
- Scoreboard entry per slot: {valid, dst, isLoad}. Every cycle all slots shift up by one; slot DEPTH-1 retires.
- Issue: slot 0 loads {1, idWrNum, idIsLoad} when idValid & idWrEnable & idWrNum≠0 & !stall & !flush. Otherwise slot 0 loads invalid.
- Match: for each used source with a nonzero register number, find the youngest (lowest-index) valid slot j with dst equal to the source. Register 0 never matches.
- The register file is write-through, so a match at j = DEPTH-1 needs neither stall nor forwarding. It yields select 0.
- Hazard, forwarding build: a matched producer is forwardable when !isLoad, or when j+1 ≥ LOAD_SLOT. `stall`=1 if any matched source in j ≤ DEPTH-2 is not forwardable. On issue, fwdSelX ← j+1 for j ≤ DEPTH-2, else 0.
- Branch: brTaken=1 forces flush=1 and stall=0, since the ID instruction is wrong-path. On the shift, slots 0..BR_SLOT-1 are invalidated and nothing issues.
- fwdSelA/B load 0 on any non-issuing cycle (stall, flush, !idValid).
- stallCount increments on cycles with stall=1. flushCount increments on brTaken=1. Both saturate at all-ones.

## Timing
- stall and flush are combinational from the current scoreboard state and the ID inputs, within the same cycle.
- Scoreboard, fwdSel and counters update on the rising edge of clk.
- fwdSel is valid during the cycle the consumer occupies EX, one cycle after its ID cycle.
- Reset: all slots invalid; stall=0, flush=0, fwdSelA/B=0, counters=0 from the first cycle after rst is sampled. A reset mid-operation discards all in-flight entries.
- Load-use penalty with defaults: 1 cycle. Stall release happens in the cycle the producer reaches slot LOAD_SLOT-1.
- brTaken and a stall condition in the same cycle: flush wins, stall=0, and stallCount is not incremented.

## Configuration
- PIPE_FWD_EN defined: forwarding as described above.
- PIPE_FWD_EN undefined: stall whenever any matched source has j ≤ DEPTH-2, regardless of isLoad. fwdSelA/B are tied to 0. LOAD_SLOT is ignored.

## Structure
- Package pipe_hazard_pkg holds:
  - the slot entry struct typedef
  - the register-zero constant
  - the fwd select width helper
- One sub-module, hazard_src_match, does the combinational youngest-match search and forwardability test. It is instantiated once per source operand.

## Test plan
- Reset: hold rst 2 cycles mid-stream -> stall=0, flush=0, fwdSelA/B=0, stallCount=flushCount=0, and no stale hazards afterwards.
- Load-use: load r8, then next ID reads r8 via rs -> stall=1 for exactly 1 cycle, then issue; fwdSelA=2 in the consumer's EX cycle; stallCount=1.
- ALU chain: add r3, then an instruction reading r3 as rt, then one reading r3 as rs -> no stall; fwdSelB=1, then fwdSelA=2.
- Register 0: producer writes r0, consumer reads r0 -> no stall, fwdSel=0.
- Branch vs stall: brTaken=1 in the cycle a load-use stall would assert -> flush=1, stall=0, slot 0 invalidated, flushCount=1, stallCount unchanged.
- PIPE_FWD_EN undefined, DEPTH=3: ALU producer r5, consumer reads r5 next -> stall for 2 cycles, fwdSel always 0, stallCount=2.

Source files
------------

// File: rtl/pipe_hazard_pkg.sv
// Shared types and helpers for the pipeline hazard controller.
// The scoreboard entry stores register numbers zero-extended to MAX_REG_NUM_WIDTH bits.
package pipe_hazard_pkg;

  localparam int MAX_REG_NUM_WIDTH = 8;

  localparam logic [MAX_REG_NUM_WIDTH-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic                         valid;
    logic [MAX_REG_NUM_WIDTH-1:0] dst;
    logic                         is_load;
  } slot_entry_t;

  function automatic int fwd_sel_width(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// ID-stage request / hazard-control response bundle for pipe_hazard_ctrl.
// The master modport is the core side; the slave modport is the controller side.
interface pipe_hazard_ctrl_if #(
  parameter int DEPTH         = 3,
  parameter int REG_NUM_WIDTH = 5,
  parameter int CNT_WIDTH     = 32
);
  import pipe_hazard_pkg::*;

  localparam int SEL_W = fwd_sel_width(DEPTH);

  logic                     idValid;
  logic [REG_NUM_WIDTH-1:0] idRs;
  logic [REG_NUM_WIDTH-1:0] idRt;
  logic                     idUseA;
  logic                     idUseB;
  logic                     idWrEnable;
  logic [REG_NUM_WIDTH-1:0] idWrNum;
  logic                     idIsLoad;
  logic                     brTaken;
  logic                     stall;
  logic                     flush;
  logic [SEL_W-1:0]         fwdSelA;
  logic [SEL_W-1:0]         fwdSelB;
  logic [CNT_WIDTH-1:0]     stallCount;
  logic [CNT_WIDTH-1:0]     flushCount;

  modport master (
    output idValid, idRs, idRt, idUseA, idUseB, idWrEnable, idWrNum, idIsLoad, brTaken,
    input  stall, flush, fwdSelA, fwdSelB, stallCount, flushCount
  );

  modport slave (
    input  idValid, idRs, idRt, idUseA, idUseB, idWrEnable, idWrNum, idIsLoad, brTaken,
    output stall, flush, fwdSelA, fwdSelB, stallCount, flushCount
  );

endinterface

// File: rtl/hazard_src_match.sv
// Youngest-producer search and forwardability test for one source operand.
// Forwarding is enabled by the PIPE_FWD_EN macro; without it every near match stalls.
module hazard_src_match
  import pipe_hazard_pkg::*;
#(
  parameter int DEPTH         = 3,
  parameter int REG_NUM_WIDTH = 5,
  parameter int LOAD_SLOT     = 2,
  parameter int SEL_W         = fwd_sel_width(DEPTH)
) (
  input  slot_entry_t [DEPTH-1:0]    i_slots,
  input  logic                       i_use,
  input  logic [REG_NUM_WIDTH-1:0]   i_src,
  output logic                       o_stall,
  output logic [SEL_W-1:0]           o_sel
);

`ifdef PIPE_FWD_EN
  localparam bit FWD_EN = 1'b1;
`else
  localparam bit FWD_EN = 1'b0;
`endif

  logic [MAX_REG_NUM_WIDTH-1:0] w_src;
  logic                         w_hit;
  logic                         w_load;
  logic                         w_near;
  logic                         w_fwdable;
  int                           w_idx;

  // NOTE: every signal gets a default at the top of always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    w_src  = MAX_REG_NUM_WIDTH'(i_src);
    w_hit  = 1'b0;
    w_load = 1'b0;
    w_idx  = 0;
    // Scan oldest to youngest so the lowest matching index wins.
    for (int j = DEPTH - 1; j >= 0; j--) begin
      if (i_slots[j].valid && (i_slots[j].dst == w_src)) begin
        w_hit  = 1'b1;
        w_idx  = j;
        w_load = i_slots[j].is_load;
      end
    end
    // A producer already in WB is covered by the write-through register file.
    w_near    = i_use && (w_src != REG_ZERO) && w_hit && (w_idx <= DEPTH - 2);
    w_fwdable = FWD_EN && (!w_load || (w_idx + 1 >= LOAD_SLOT));
    o_stall   = w_near && !w_fwdable;
    o_sel     = (FWD_EN && w_near) ? SEL_W'(w_idx + 1) : '0;
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Interlock, forwarding-select and flush controller built on a shift-register write scoreboard.
// Define PIPE_FWD_EN to enable operand forwarding; otherwise fwdSelA/B stay 0 and all near hazards stall.
module pipe_hazard_ctrl
  import pipe_hazard_pkg::*;
#(
  parameter int DEPTH         = 3,
  parameter int REG_NUM_WIDTH = 5,
  parameter int LOAD_SLOT     = 2,
  parameter int BR_SLOT       = 1,
  parameter int CNT_WIDTH     = 32
) (
  input  logic               clk,
  input  logic               rst,
  pipe_hazard_ctrl_if.slave  bus
);

  localparam int SEL_W = fwd_sel_width(DEPTH);

  slot_entry_t [DEPTH-1:0] r_sb;
  slot_entry_t             w_new_entry;
  logic                    w_stall_a;
  logic                    w_stall_b;
  logic                    w_stall;
  logic                    w_flush;
  logic                    w_advance;
  logic                    w_issue;
  logic [SEL_W-1:0]        w_sel_a;
  logic [SEL_W-1:0]        w_sel_b;
  logic [SEL_W-1:0]        r_fwd_a;
  logic [SEL_W-1:0]        r_fwd_b;
  logic [CNT_WIDTH-1:0]    r_stall_cnt;
  logic [CNT_WIDTH-1:0]    r_flush_cnt;

  hazard_src_match #(
    .DEPTH(DEPTH), .REG_NUM_WIDTH(REG_NUM_WIDTH), .LOAD_SLOT(LOAD_SLOT), .SEL_W(SEL_W)
  ) u_match_a (
    .i_slots (r_sb),
    .i_use   (bus.idValid & bus.idUseA),
    .i_src   (bus.idRs),
    .o_stall (w_stall_a),
    .o_sel   (w_sel_a)
  );

  hazard_src_match #(
    .DEPTH(DEPTH), .REG_NUM_WIDTH(REG_NUM_WIDTH), .LOAD_SLOT(LOAD_SLOT), .SEL_W(SEL_W)
  ) u_match_b (
    .i_slots (r_sb),
    .i_use   (bus.idValid & bus.idUseB),
    .i_src   (bus.idRt),
    .o_stall (w_stall_b),
    .o_sel   (w_sel_b)
  );

  always_comb begin
    // A taken branch makes the ID instruction wrong-path, so it can never stall.
    w_flush     = bus.brTaken;
    w_stall     = bus.idValid & ~bus.brTaken & (w_stall_a | w_stall_b);
    w_advance   = bus.idValid & ~w_stall & ~w_flush;
    w_issue     = w_advance & bus.idWrEnable &
                  (MAX_REG_NUM_WIDTH'(bus.idWrNum) != REG_ZERO);
    w_new_entry = '0;
    if (w_issue) begin
      w_new_entry.valid   = 1'b1;
      w_new_entry.dst     = MAX_REG_NUM_WIDTH'(bus.idWrNum);
      w_new_entry.is_load = bus.idIsLoad;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sb        <= '0;
      r_fwd_a     <= '0;
      r_fwd_b     <= '0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      for (int k = DEPTH - 1; k >= 1; k--) begin
        r_sb[k] <= (w_flush && (k < BR_SLOT)) ? '0 : r_sb[k-1];
      end
      r_sb[0] <= w_new_entry;
      r_fwd_a <= w_advance ? w_sel_a : '0;
      r_fwd_b <= w_advance ? w_sel_b : '0;
      if (w_stall && (r_stall_cnt != {CNT_WIDTH{1'b1}})) begin
        r_stall_cnt <= r_stall_cnt + CNT_WIDTH'(1);
      end
      if (w_flush && (r_flush_cnt != {CNT_WIDTH{1'b1}})) begin
        r_flush_cnt <= r_flush_cnt + CNT_WIDTH'(1);
      end
    end
  end

  assign bus.stall      = w_stall;
  assign bus.flush      = w_flush;
  assign bus.fwdSelA    = r_fwd_a;
  assign bus.fwdSelB    = r_fwd_b;
  assign bus.stallCount = r_stall_cnt;
  assign bus.flushCount = r_flush_cnt;

endmodule
